// File: rtl/assoc_refill_cache.sv
// assoc_refill_cache: two-way set-associative read-only cache with true LRU
// replacement and an owned multi-beat line refill engine. Hits answer
// combinationally; a miss stalls the requester until the line is installed.
module assoc_refill_cache #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int SET_BITS    = 2,
    parameter int OFFSET_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  flush,
    output logic                  hit,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int SETS    = 1 << SET_BITS;
    localparam int WORDS   = 1 << OFFSET_BITS;
    localparam int TAG_LSB = SET_BITS + OFFSET_BITS + 2;
    localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_INSTALL} state_t;

    state_t                   r_state;
    logic [SETS-1:0]          r_valid [2];
    logic [SETS-1:0]          r_lru;
    logic [TAG_W-1:0]         r_tag   [2][SETS];
    logic [DATA_WIDTH-1:0]    r_data  [2][SETS][WORDS];
    logic                     r_vic;
    logic [SET_BITS-1:0]      r_idx;
    logic [TAG_W-1:0]         r_tag_l;
    logic [OFFSET_BITS-1:0]   r_beat;
    logic                     r_flush_pend;
    logic                     r_mem_req;
    logic [ADDR_WIDTH-1:0]    r_mem_addr;
    logic [31:0]              r_hit_count;
    logic [31:0]              r_miss_count;

    logic [OFFSET_BITS-1:0]   w_word;
    logic [SET_BITS-1:0]      w_index;
    logic [TAG_W-1:0]         w_tag;
    logic                     w_match0;
    logic                     w_match1;
    logic                     w_idle;
    logic                     w_hit;
    logic                     w_victim;
    logic                     w_discard;
    logic                     w_unused_byte;

    assign w_word        = addr[OFFSET_BITS+1:2];
    assign w_index       = addr[OFFSET_BITS+2 +: SET_BITS];
    assign w_tag         = addr[ADDR_WIDTH-1:TAG_LSB];
    assign w_unused_byte = &{1'b0, addr[1:0]};

    assign w_match0  = r_valid[0][w_index] && (r_tag[0][w_index] == w_tag);
    assign w_match1  = r_valid[1][w_index] && (r_tag[1][w_index] == w_tag);
    assign w_idle    = (r_state == S_IDLE);
    assign w_hit     = w_idle && rd_en && (w_match0 || w_match1);
    // First invalid way (way0 preferred), otherwise the LRU way.
    assign w_victim  = !r_valid[0][w_index] ? 1'b0 :
                       !r_valid[1][w_index] ? 1'b1 : r_lru[w_index];
    // A flush seen during the refill (or in the install cycle) drops the line.
    assign w_discard = r_flush_pend || flush;

    assign hit        = w_hit;
    assign stall      = (w_idle && rd_en && !w_hit) || !w_idle;
    // Install never lets both ways match, so match1 alone selects the way.
    assign data_out   = w_hit ? r_data[w_match1][w_index][w_word] : '0;
    assign mem_req    = r_mem_req;
    assign mem_addr   = r_mem_addr;
    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

    // Control FSM: lookup/miss handling, beat counting, install, flush, counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_valid[0]   <= '0;
            r_valid[1]   <= '0;
            r_lru        <= '0;
            r_vic        <= 1'b0;
            r_idx        <= '0;
            r_tag_l      <= '0;
            r_beat       <= '0;
            r_flush_pend <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        r_lru[w_index] <= ~w_match1;
                        if (r_hit_count != '1) r_hit_count <= r_hit_count + 32'd1;
                    end else if (rd_en) begin
                        r_vic                     <= w_victim;
                        r_idx                     <= w_index;
                        r_tag_l                   <= w_tag;
                        r_valid[w_victim][w_index] <= 1'b0;
                        if (r_miss_count != '1) r_miss_count <= r_miss_count + 32'd1;
                        r_mem_req                 <= 1'b1;
                        r_mem_addr                <= {w_tag, w_index, {(OFFSET_BITS+2){1'b0}}};
                        r_beat                    <= '0;
                        r_flush_pend              <= 1'b0;
                        r_state                   <= S_REFILL;
                    end
                    if (flush) begin
                        r_valid[0] <= '0;
                        r_valid[1] <= '0;
                        r_lru      <= '0;
                    end
                end
                S_REFILL: begin
                    if (flush) r_flush_pend <= 1'b1;
                    if (mem_valid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == '1) begin
                            r_mem_req <= 1'b0;
                            r_state   <= S_INSTALL;
                        end
                    end
                end
                S_INSTALL: begin
                    if (w_discard) begin
                        r_valid[0] <= '0;
                        r_valid[1] <= '0;
                        r_lru      <= '0;
                    end else begin
                        r_valid[r_vic][r_idx] <= 1'b1;
                        r_lru[r_idx]          <= ~r_vic;
                    end
                    r_flush_pend <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line storage: refill beats land in the victim way, tag written at install.
    always_ff @(posedge clk) begin
        if (r_state == S_REFILL && mem_valid)
            r_data[r_vic][r_idx][r_beat] <= mem_data;
        if (r_state == S_INSTALL && !w_discard)
            r_tag[r_vic][r_idx] <= r_tag_l;
    end

endmodule

// File: tb/tb_assoc_refill_cache.sv
// Testbench for assoc_refill_cache: directed scenarios with literal
// expectations plus randomized traffic against a behavioural cache model.
module tb_assoc_refill_cache;

    localparam int SETS  = 4;
    localparam int WORDS = 4;

    logic        clk, rst_n, rd_en, flush, mem_valid;
    logic [31:0] addr, mem_data;
    logic        hit, stall, mem_req;
    logic [31:0] data_out, mem_addr, hit_count, miss_count;

    assoc_refill_cache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SET_BITS(2), .OFFSET_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .addr(addr), .flush(flush),
        .hit(hit), .stall(stall), .data_out(data_out),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Main memory contents as a function of the word address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a >> 2) + 32'h60;
    endfunction

    // ---------------- behavioural model ----------------
    bit          m_valid [2][SETS];
    logic [25:0] m_tag   [2][SETS];
    logic [31:0] m_data  [2][SETS][WORDS];
    bit          m_lru   [SETS];
    int          m_left;      // refill beats still owed by memory
    bit          m_inst;      // line complete, installs at next edge
    bit          m_fpend;
    int          m_way, m_set, m_k;
    logic [25:0] m_ltag;
    logic [31:0] m_line;
    logic [31:0] m_hits, m_misses;

    function automatic bit m_busy();
        return (m_left > 0) || m_inst;
    endfunction

    function automatic int lookup(input logic [31:0] a);
        for (int w = 0; w < 2; w++)
            if (m_valid[w][a[5:4]] && m_tag[w][a[5:4]] == a[31:6]) return w;
        return -1;
    endfunction

    task automatic m_clear();
        for (int s = 0; s < SETS; s++) begin
            m_valid[0][s] = 0; m_valid[1][s] = 0; m_lru[s] = 0;
        end
    endtask

    task automatic model_reset();
        m_clear();
        m_left = 0; m_inst = 0; m_fpend = 0; m_k = 0;
        m_line = '0; m_hits = '0; m_misses = '0;
    endtask

    task automatic model_step();
        int w, v, s;
        if (m_inst) begin
            if (m_fpend || flush) m_clear();
            else begin
                m_valid[m_way][m_set] = 1;
                m_tag[m_way][m_set]   = m_ltag;
                m_lru[m_set]          = (m_way == 0);
            end
            m_inst = 0; m_fpend = 0;
        end else if (m_left > 0) begin
            if (flush) m_fpend = 1;
            if (mem_valid) begin
                m_data[m_way][m_set][m_k] = mem_data;
                m_k++; m_left--;
                if (m_left == 0) m_inst = 1;
            end
        end else begin
            if (rd_en) begin
                w = lookup(addr);
                s = int'(addr[5:4]);
                if (w >= 0) begin
                    m_lru[s] = (w == 0);
                    if (m_hits != 32'hFFFF_FFFF) m_hits++;
                end else begin
                    v = !m_valid[0][s] ? 0 : !m_valid[1][s] ? 1 : int'(m_lru[s]);
                    m_valid[v][s] = 0;
                    if (m_misses != 32'hFFFF_FFFF) m_misses++;
                    m_way = v; m_set = s; m_ltag = addr[31:6];
                    m_line = {addr[31:4], 4'b0};
                    m_left = WORDS; m_k = 0;
                end
            end
            if (flush) m_clear();
        end
    endtask

    always @(posedge clk) if (rst_n) model_step();

    // ---------------- per-cycle compare ----------------
    bit last_stall;

    task automatic check_outputs();
        logic e_hit, e_stall;
        logic [31:0] e_data;
        int w;
        e_hit = 0; e_data = '0; e_stall = 1;
        if (!m_busy()) begin
            w = lookup(addr);
            e_hit   = rd_en && (w >= 0);
            e_data  = e_hit ? m_data[w][addr[5:4]][addr[3:2]] : 32'h0;
            e_stall = rd_en && !e_hit;
        end
        chk("hit", {31'b0, hit}, {31'b0, e_hit});
        chk("stall", {31'b0, stall}, {31'b0, e_stall});
        chk("data_out", data_out, e_data);
        chk("mem_req", {31'b0, mem_req}, {31'b0, m_left > 0});
        if (m_left > 0) chk("mem_addr", mem_addr, m_line);
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_misses);
        last_stall = e_stall;
    endtask

    // ---------------- driver with memory responder ----------------
    int mode;        // 0: beat every cycle, 1: 0/1 toggle, 2: random
    bit tog, prev_fire;
    int resp_k;

    task automatic cycle(input bit rd, input logic [31:0] a, input bit fl);
        bit mv;
        @(negedge clk);
        if (prev_fire) resp_k++;
        if (!mem_req) begin resp_k = 0; tog = 0; end
        rd_en = rd; addr = a; flush = fl;
        if (mem_req) begin
            case (mode)
                0: mv = 1;
                1: begin mv = tog; tog = ~tog; end
                default: mv = 1'($urandom_range(0, 1));
            endcase
            mem_data = memfn(mem_addr + 32'(resp_k * 4));
        end else begin
            mv = 1'($urandom_range(0, 1));
            mem_data = $urandom;
        end
        mem_valid = mv;
        prev_fire = mem_req && mv;
        #1 check_outputs();
    endtask

    task automatic access(input logic [31:0] a, output bit first_hit, output logic [31:0] d);
        int n;
        cycle(1, a, 0);
        first_hit = hit;
        n = 0;
        while (!hit && n < 40) begin
            cycle(1, a, 0);
            n++;
        end
        chk("access_done", {31'b0, hit}, 32'd1);
        d = data_out;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; rd_en = 0; flush = 0; mem_valid = 0;
        model_reset();
        prev_fire = 0;
        #1 check_outputs();
        repeat (2) cycle(0, 32'h0, 0);
        rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          fh, lrd, rd, fl;
        logic [31:0] d, laddr, a;
        int          n;
        rst_n = 1; rd_en = 0; flush = 0; addr = '0; mem_valid = 0; mem_data = '0;
        mode = 0; tog = 0; prev_fire = 0; resp_k = 0;
        do_reset();
        chk("rst_hit_count", hit_count, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        // First miss and its exact refill timeline.
        cycle(1, 32'h100, 0);
        chk("T_hit", {31'b0, hit}, 32'd0);
        chk("T_stall", {31'b0, stall}, 32'd1);
        chk("T_mem_req", {31'b0, mem_req}, 32'd0);
        cycle(1, 32'h100, 0);
        chk("T1_mem_req", {31'b0, mem_req}, 32'd1);
        chk("T1_mem_addr", mem_addr, 32'h100);
        repeat (4) cycle(1, 32'h100, 0);
        chk("T5_stall", {31'b0, stall}, 32'd1);
        cycle(1, 32'h100, 0);
        chk("T6_hit", {31'b0, hit}, 32'd1);
        chk("T6_data", data_out, 32'hA0);
        cycle(1, 32'h10C, 0);
        chk("hit_10C", {31'b0, hit}, 32'd1);
        chk("data_10C", data_out, 32'hA3);
        cycle(0, 32'h0, 0);
        chk("cnt_hits_2", hit_count, 32'd2);
        chk("cnt_miss_1", miss_count, 32'd1);

        // Conflict in set 0 with LRU eviction.
        access(32'h140, fh, d);
        chk("140_miss", {31'b0, fh}, 32'd0);
        chk("140_data", d, 32'hB0);
        access(32'h100, fh, d);
        chk("100_hit", {31'b0, fh}, 32'd1);
        access(32'h180, fh, d);
        chk("180_miss", {31'b0, fh}, 32'd0);
        chk("180_data", d, 32'hC0);
        access(32'h100, fh, d);
        chk("100_kept", {31'b0, fh}, 32'd1);
        chk("100_kept_data", d, 32'hA0);
        access(32'h140, fh, d);
        chk("140_evicted", {31'b0, fh}, 32'd0);

        // Stretched refill with alternating beats.
        mode = 1;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(1, 32'h200, 0);
            if (mem_req) n++;
            if (hit) break;
        end
        chk("stretch_req_cycles", 32'(n), 32'd8);
        chk("stretch_data0", data_out, 32'hE0);
        mode = 0;
        access(32'h20C, fh, d);
        chk("stretch_w3_hit", {31'b0, fh}, 32'd1);
        chk("stretch_w3_data", d, 32'hE3);

        // Flush in IDLE.
        cycle(0, 32'h0, 1);
        access(32'h100, fh, d);
        chk("flush_100_miss", {31'b0, fh}, 32'd0);
        access(32'h20C, fh, d);
        chk("flush_20C_miss", {31'b0, fh}, 32'd0);

        // Flush during REFILL: line discarded, re-read misses.
        cycle(1, 32'h240, 0);
        cycle(1, 32'h240, 0);
        cycle(1, 32'h240, 1);
        repeat (3) cycle(1, 32'h240, 0);
        cycle(1, 32'h240, 0);
        chk("flushrefill_miss", {31'b0, hit}, 32'd0);
        chk("flushrefill_stall", {31'b0, stall}, 32'd1);
        access(32'h240, fh, d);
        chk("240_data", d, 32'hF0);

        // Reset in the middle of a refill.
        cycle(1, 32'h300, 0);
        cycle(1, 32'h300, 0);
        cycle(1, 32'h300, 0);
        @(negedge clk);
        rst_n = 0; rd_en = 0; flush = 0; mem_valid = 0;
        model_reset();
        prev_fire = 0;
        #1;
        chk("rst_mid_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mid_hits", hit_count, 32'd0);
        chk("rst_mid_miss", miss_count, 32'd0);
        check_outputs();
        repeat (2) cycle(0, 32'h0, 0);
        rst_n = 1;
        access(32'h240, fh, d);
        chk("post_rst_miss", {31'b0, fh}, 32'd0);

        // Counter totals: two misses (each ending in a hit) plus one more hit.
        access(32'h100, fh, d);
        access(32'h244, fh, d);
        chk("cnt_extra_hit", {31'b0, fh}, 32'd1);
        cycle(0, 32'h0, 0);
        chk("cnt_hits_3", hit_count, 32'd3);
        chk("cnt_miss_2", miss_count, 32'd2);

        // Saturation of the hit counter.
        force dut.r_hit_count = 32'hFFFF_FFFE;
        m_hits = 32'hFFFF_FFFE;
        cycle(0, 32'h0, 0);
        release dut.r_hit_count;
        cycle(1, 32'h100, 0);
        cycle(1, 32'h104, 0);
        cycle(1, 32'h108, 0);
        cycle(0, 32'h0, 0);
        chk("hit_count_sat", hit_count, 32'hFFFF_FFFF);

        // Randomized traffic.
        do_reset();
        mode = 2;
        lrd = 0; laddr = '0;
        for (int i = 0; i < 3000; i++) begin
            if (m_busy()) begin
                cycle(lrd, laddr, ($urandom_range(0, 15) == 0));
            end else if (last_stall) begin
                cycle(lrd, laddr, 0);
            end else begin
                rd = ($urandom_range(0, 3) != 0);
                a  = (32'($urandom_range(0, 5)) << 6) | (32'($urandom_range(0, 3)) << 4) |
                     (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
                if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
                fl = !rd && ($urandom_range(0, 19) == 0);
                lrd = rd; laddr = a;
                cycle(rd, a, fl);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
